// File: rtl/wishbone_slave_ram.sv
// wishbone_slave_ram: Wishbone slave RAM with byte-lane writes and a one-cycle ACK pulse.
// Define WB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states between acceptance and ACK.
module wishbone_slave_ram #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic                  i_WE,
    input  logic [3:0]            i_SEL,
    input  logic                  i_STB,
    input  logic                  i_CYC,
    output logic                  o_ACK,
    input  logic                  i_TAGN,
    output logic                  o_TAGN
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * DEPTH);
    localparam bit WAIT_EN = `ifdef WB_SLAVE_WAIT_EN 1'b1 `else 1'b0 `endif;
    localparam int WAIT_CNT = WAIT_EN ? WAIT_CYCLES : 0;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]         r_idx, w_idx;
    logic [DATA_WIDTH-1:0] r_dat, w_dat, r_odata;
    logic [3:0]            r_sel, w_sel;
    logic                  r_we, w_we, r_tagn, w_tagn, r_ack, r_otag;
    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_hit, w_req, w_commit;

    assign w_off = i_ADDR - ADDR_WIDTH'(BASE_ADDR);
    assign w_hit = (i_ADDR >= ADDR_WIDTH'(BASE_ADDR)) && ({1'b0, w_off} < SPAN);
    assign w_req = i_CYC && i_STB && w_hit;

    // In IDLE the live request bypasses the latches so a zero-wait write commits on its accept edge.
    assign w_idx  = (r_state == IDLE) ? w_off[IW+1:2] : r_idx;
    assign w_dat  = (r_state == IDLE) ? i_DATA : r_dat;
    assign w_sel  = (r_state == IDLE) ? i_SEL : r_sel;
    assign w_we   = (r_state == IDLE) ? i_WE : r_we;
    assign w_tagn = (r_state == IDLE) ? i_TAGN : r_tagn;
    assign w_commit = i_RSTn && w_we && (w_next == ACK);

`ifdef WB_SLAVE_WAIT_EN
    localparam int CW = $clog2(WAIT_CYCLES + 2);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn)
            r_cnt <= '0;
        else
            r_cnt <= (w_next != WAIT) ? '0 : (r_state == IDLE) ? CW'(WAIT_CNT) : r_cnt - CW'(1);
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_req ? ((WAIT_CNT != 0) ? WAIT : ACK) : IDLE;
`ifdef WB_SLAVE_WAIT_EN
            WAIT:    w_next = !i_CYC ? IDLE : (r_cnt == CW'(1)) ? ACK : WAIT;
`endif
            ACK:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_tagn  <= 1'b0;
            r_ack   <= 1'b0;
            r_odata <= '0;
            r_otag  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_idx  <= w_off[IW+1:2];
                r_dat  <= i_DATA;
                r_sel  <= i_SEL;
                r_we   <= i_WE;
                r_tagn <= i_TAGN;
            end
            r_ack   <= (w_next == ACK);
            r_odata <= (w_next == ACK && !w_we) ? r_mem[w_idx] : '0;
            r_otag  <= (w_next == ACK) ? w_tagn : 1'b1;
        end
    end

    // Memory is deliberately left out of reset so contents survive it.
    always_ff @(posedge i_CLK) begin
        if (w_commit)
            for (int b = 0; b < 4; b++)
                if (w_sel[b])
                    r_mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
    end

    assign o_ACK  = r_ack;
    assign o_DATA = r_odata;
    assign o_TAGN = r_otag;
endmodule

// File: tb/tb_wishbone_slave_ram.sv
// tb_wishbone_slave_ram: directed self-checking bench for wishbone_slave_ram.
// Latency expectations follow WB_SLAVE_WAIT_EN (2 wait states when defined, none otherwise).
module tb_wishbone_slave_ram;
    localparam int W = `ifdef WB_SLAVE_WAIT_EN 2 `else 0 `endif;

    logic        i_CLK = 1'b0;
    logic        i_RSTn = 1'b1;
    logic [31:0] i_ADDR = '0;
    logic [31:0] i_DATA = '0;
    logic [31:0] o_DATA;
    logic        i_WE = 1'b0;
    logic [3:0]  i_SEL = '0;
    logic        i_STB = 1'b0;
    logic        i_CYC = 1'b0;
    logic        o_ACK;
    logic        i_TAGN = 1'b1;
    logic        o_TAGN;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 i_CLK = ~i_CLK;

    wishbone_slave_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h0000_1000),
        .DEPTH(256), .WAIT_CYCLES(2)
    ) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_ADDR(i_ADDR), .i_DATA(i_DATA),
        .o_DATA(o_DATA), .i_WE(i_WE), .i_SEL(i_SEL), .i_STB(i_STB),
        .i_CYC(i_CYC), .o_ACK(o_ACK), .i_TAGN(i_TAGN), .o_TAGN(o_TAGN)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic we, input logic [31:0] d,
                        input logic [3:0] sel, input logic tg,
                        output logic [31:0] rd, output logic rtag, output int lat);
        @(posedge i_CLK); #1;
        i_ADDR = a; i_WE = we; i_DATA = d; i_SEL = sel; i_TAGN = tg;
        i_CYC = 1'b1; i_STB = 1'b1;
        lat = -1; rd = '0; rtag = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_CLK);
            if (o_ACK) begin
                lat = c; rd = o_DATA; rtag = o_TAGN;
                break;
            end
        end
        @(posedge i_CLK); #1;
        i_CYC = 1'b0; i_STB = 1'b0; i_WE = 1'b0;
        @(negedge i_CLK);
        chk("ack_one_cycle", 32'(o_ACK), 32'd0);
        chk("data_zero_after_ack", o_DATA, 32'd0);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] sel, input logic tg);
        logic [31:0] rd;
        logic rtag;
        int lat;
        xfer(a, 1'b1, d, sel, tg, rd, rtag, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(W + 1));
        chk({tag, "_tag"}, 32'(rtag), 32'(tg));
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp,
                          input logic tg);
        logic [31:0] rd;
        logic rtag;
        int lat;
        xfer(a, 1'b0, 32'h0, 4'h0, tg, rd, rtag, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(W + 1));
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_tag"}, 32'(rtag), 32'(tg));
    endtask

    task automatic miss(input string tag, input logic [31:0] a);
        @(posedge i_CLK); #1;
        i_ADDR = a; i_WE = 1'b0; i_CYC = 1'b1; i_STB = 1'b1; i_TAGN = 1'b0;
        repeat (10) begin
            @(negedge i_CLK);
            chk({tag, "_ack"}, 32'(o_ACK), 32'd0);
            chk({tag, "_data"}, o_DATA, 32'd0);
        end
        @(posedge i_CLK); #1;
        i_CYC = 1'b0; i_STB = 1'b0;
    endtask

    initial begin
        #2 i_RSTn = 1'b0;
        #1;
        chk("rst_ack", 32'(o_ACK), 32'd0);
        chk("rst_data", o_DATA, 32'd0);
        chk("rst_tagn", 32'(o_TAGN), 32'd1);
        repeat (2) @(posedge i_CLK);
        #1 i_RSTn = 1'b1;

        wr("wr1004", 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd_chk("rd1004", 32'h0000_1004, 32'hDEAD_BEEF, 1'b1);
        rd_chk("rd1006_lowbits", 32'h0000_1006, 32'hDEAD_BEEF, 1'b0);

        wr("wr1008_full", 32'h0000_1008, 32'h1122_3344, 4'hF, 1'b1);
        wr("wr1008_lanes", 32'h0000_1008, 32'hAABB_CCDD, 4'b0101, 1'b0);
        rd_chk("rd1008_lanes", 32'h0000_1008, 32'h11BB_33DD, 1'b1);
        wr("wr1008_sel0", 32'h0000_1008, 32'hFFFF_FFFF, 4'h0, 1'b1);
        rd_chk("rd1008_sel0", 32'h0000_1008, 32'h11BB_33DD, 1'b0);

        wr("wr1000", 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 1'b1);
        rd_chk("rd1000_tag", 32'h0000_1000, 32'hCAFE_F00D, 1'b0);
        wr("wr13fc_top", 32'h0000_13FC, 32'h0BAD_C0DE, 4'hF, 1'b0);
        rd_chk("rd13fc_top", 32'h0000_13FC, 32'h0BAD_C0DE, 1'b1);

        miss("miss_0ffc", 32'h0000_0FFC);
        miss("miss_1400", 32'h0000_1400);

`ifdef WB_SLAVE_WAIT_EN
        begin
            int lat;
            logic [31:0] d;
            wr("wr1010_old", 32'h0000_1010, 32'h1234_5678, 4'hF, 1'b0);
            @(posedge i_CLK); #1;
            i_ADDR = 32'h0000_1010; i_WE = 1'b1; i_DATA = 32'h55; i_SEL = 4'hF;
            i_CYC = 1'b1; i_STB = 1'b1;
            @(posedge i_CLK); #1;
            i_CYC = 1'b0; i_STB = 1'b0; i_WE = 1'b0;
            repeat (6) begin
                @(negedge i_CLK);
                chk("abort_no_ack", 32'(o_ACK), 32'd0);
            end
            rd_chk("rd1010_after_abort", 32'h0000_1010, 32'h1234_5678, 1'b0);

            @(posedge i_CLK); #1;
            i_ADDR = 32'h0000_1000; i_WE = 1'b0; i_CYC = 1'b1; i_STB = 1'b1; i_TAGN = 1'b0;
            @(posedge i_CLK); #1;
            i_STB = 1'b0;
            lat = -1; d = '0;
            for (int c = 1; c < 12; c++) begin
                @(negedge i_CLK);
                if (o_ACK) begin
                    lat = c; d = o_DATA;
                    break;
                end
            end
            chk("stb_low_lat", 32'(lat), 32'(W + 1));
            chk("stb_low_data", d, 32'hCAFE_F00D);
            @(posedge i_CLK); #1;
            i_CYC = 1'b0;
        end
`endif

        @(posedge i_CLK); #1;
        i_ADDR = 32'h0000_1004; i_WE = 1'b1; i_DATA = 32'h9999_9999; i_SEL = 4'hF;
        i_TAGN = 1'b0; i_CYC = 1'b1; i_STB = 1'b1;
        @(posedge i_CLK); #2;
        i_RSTn = 1'b0;
        #1;
        chk("midrst_ack", 32'(o_ACK), 32'd0);
        chk("midrst_data", o_DATA, 32'd0);
        chk("midrst_tagn", 32'(o_TAGN), 32'd1);
        i_CYC = 1'b0; i_STB = 1'b0; i_WE = 1'b0;
        @(posedge i_CLK); #1;
        i_RSTn = 1'b1;
        rd_chk("rd1004_after_rst", 32'h0000_1004, (W > 0) ? 32'hDEAD_BEEF : 32'h9999_9999, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wishbone_slave_ram.md
WISHBONE_SLAVE_RAM -- requirements
Module: wishbone_slave_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address bus width in bits.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_1000: byte address of word 0.
REQ-004 SHALL have parameter DEPTH, default 256: number of 32-bit words; power of two.
REQ-005 SHALL have parameter WAIT_CYCLES, default 2: wait states before ACK; effective only with the configuration macro.
REQ-006 SHALL have port i_CLK, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port i_RSTn, input, 1: reset; asynchronous, active-low.
REQ-008 SHALL have port i_ADDR, input, ADDR_WIDTH: Wishbone byte address.
REQ-009 SHALL have port i_DATA, input, DATA_WIDTH: Wishbone write data.
REQ-010 SHALL have port o_DATA, output, DATA_WIDTH: Wishbone read data.
REQ-011 SHALL have port i_WE, input, 1: write enable; 1 = write, 0 = read.
REQ-012 SHALL have port i_SEL, input, 4: byte-lane selects; bit n = bits 8n+7:8n.
REQ-013 SHALL have port i_STB, input, 1: strobe.
REQ-014 SHALL have port i_CYC, input, 1: bus cycle valid.
REQ-015 SHALL have port o_ACK, output, 1: transfer acknowledge.
REQ-016 SHALL have port i_TAGN, input, 1: master tag.
REQ-017 SHALL have port o_TAGN, output, 1: tag echo.

Function
REQ-018 SHALL run FSM states IDLE, WAIT, ACK, DONE.
REQ-019 SHALL decode hit = i_ADDR in [BASE_ADDR, BASE_ADDR+4*DEPTH); word index = (i_ADDR-BASE_ADDR)>>2; i_ADDR[1:0] ignored.
REQ-020 SHALL, in IDLE with i_CYC & i_STB & hit, latch address index, data, WE, SEL and TAGN, then go to WAIT (wait count > 0) or ACK (wait count = 0).
REQ-021 SHALL stay in IDLE with o_ACK low on a miss, leaving the bus to other slaves.
REQ-022 SHALL, in WAIT, decrement a counter loaded with the wait count and go to ACK on the cycle after it reaches 1.
REQ-023 SHALL drive o_ACK high for exactly one cycle, in state ACK only.
REQ-024 SHALL commit a write on the rising edge entering ACK; only lanes whose SEL bit is set change; SEL = 0 writes nothing but still ACKs.
REQ-025 SHALL register read data from the latched word into o_DATA, valid while o_ACK is high; o_DATA = 0 otherwise.
REQ-026 SHALL drive o_TAGN = latched i_TAGN while o_ACK is high, else 1.
REQ-027 SHALL go ACK -> DONE -> IDLE unconditionally; requests are ignored in DONE, giving a one-cycle recovery and a peak rate of one transfer per WAIT+3 cycles.
REQ-028 SHALL, if i_CYC drops in WAIT, abort to IDLE with no write and no ACK; i_STB low alone in WAIT does not abort.
REQ-029 SHALL keep memory contents undefined after power-up and not clear them on reset.

Reset
REQ-030 SHALL, while i_RSTn = 0 (asynchronous), force state IDLE, o_ACK = 0, o_DATA = 0, o_TAGN = 1, wait counter = 0, latches = 0.
REQ-031 SHALL discard any pending write when reset asserts mid-transaction; memory is unaffected.

Configuration
REQ-032 SHALL use macro WB_SLAVE_WAIT_EN: when defined, wait count = WAIT_CYCLES and WAIT is used; when undefined, wait count = 0, the WAIT state and counter are not synthesized, and ACK follows acceptance by one cycle.

Verification
REQ-033 SHALL cover a single write: macro off, write 0xDEADBEEF to 0x1004 with SEL = 4'hF -> ACK in the cycle after acceptance, one cycle wide; a read of 0x1004 returns 0xDEADBEEF with ACK.
REQ-034 SHALL cover byte lanes: word 0x1008 = 0x11223344, write 0xAABBCCDD with SEL = 4'b0101 -> read returns 0x11BB33DD.
REQ-035 SHALL cover wait states: macro on, WAIT_CYCLES = 2, read 0x1000 -> ACK exactly 3 cycles after acceptance; o_TAGN = i_TAGN of the request during ACK.
REQ-036 SHALL cover a miss: read 0x0FFC or 0x1400 with CYC = STB = 1 held for 10 cycles -> o_ACK stays 0 and o_DATA stays 0.
REQ-037 SHALL cover abort: macro on, write 0x55 to 0x1010, drop i_CYC in the first WAIT cycle -> no ACK; a later read of 0x1010 returns the old value.
REQ-038 SHALL cover reset mid-transaction: assert i_RSTn = 0 during WAIT -> o_ACK = 0, o_DATA = 0, o_TAGN = 1 immediately without a clock edge; the next request completes normally.
